// File: rtl/data_mem_responder.sv
// Single-cycle-response data memory slave: 2^ADDR_BITS x 64-bit little-endian words.
// Define MEM_ALIGN_CHECK_EN to reject misaligned accesses with mem_err instead of forcing alignment.
module data_mem_responder #(
    parameter int         ADDR_BITS = 8,
    parameter logic [1:0] SEL_CODE  = 2'b01
) (
    input  logic        clock,
    input  logic        reset_n,
    input  logic [1:0]  mem_cs,
    input  logic        mem_write_en,
    input  logic [1:0]  size,
    input  logic [63:0] address,
    input  logic [63:0] data_in,
    output logic [63:0] data_out,
    output logic        data_out_en,
    output logic        ready,
    output logic        mem_err,
    output logic        state_o
);

    localparam int DEPTH = 1 << ADDR_BITS;

    typedef enum logic {
        IDLE = 1'b0,
        RESP = 1'b1
    } state_e;

    state_e state_q, state_d;

    logic [63:0]          mem_q [DEPTH];
    logic [ADDR_BITS-1:0] idx;
    logic [2:0]           off_raw;
    logic [2:0]           align_mask;
    logic [2:0]           off;
    logic                 bad_align;
    logic                 accept;
    logic                 we;
    logic [7:0]           be_base;
    logic [7:0]           be;
    logic [63:0]          lane_mask;
    logic [63:0]          rd_word;
    logic [63:0]          rd_lane;
    logic [63:0]          wr_shift;
    logic [63:0]          wr_word;
    logic                 unused_addr;

    logic                 ready_d, den_d;
    logic [63:0]          dout_d;
    logic                 ready_q, den_q;
    logic [63:0]          dout_q;

    assign idx         = address[ADDR_BITS+2:3];
    assign off_raw     = address[2:0];
    assign unused_addr = ^address[63:ADDR_BITS+3];

    always_comb begin
        align_mask = 3'b111;
        lane_mask  = 64'h0000_0000_0000_00FF;
        be_base    = 8'h01;
        case (size)
            2'b01: begin
                align_mask = 3'b110;
                lane_mask  = 64'h0000_0000_0000_FFFF;
                be_base    = 8'h03;
            end
            2'b10: begin
                align_mask = 3'b100;
                lane_mask  = 64'h0000_0000_FFFF_FFFF;
                be_base    = 8'h0F;
            end
            2'b11: begin
                align_mask = 3'b000;
                lane_mask  = 64'hFFFF_FFFF_FFFF_FFFF;
                be_base    = 8'hFF;
            end
            default: ;
        endcase
        // Offset bits below the access size are dropped, so lanes are always aligned.
        off      = off_raw & align_mask;
        be       = be_base << off;
        rd_word  = mem_q[idx];
        rd_lane  = (rd_word >> {off, 3'b000}) & lane_mask;
        wr_shift = (data_in & lane_mask) << {off, 3'b000};
        for (int i = 0; i < 8; i++) begin
            wr_word[i*8 +: 8] = be[i] ? wr_shift[i*8 +: 8] : rd_word[i*8 +: 8];
        end
    end

    // Handshake: a request is any cycle with mem_cs == SEL_CODE while IDLE; the next
    // cycle is RESP, where ready pulses for exactly one cycle and mem_cs is ignored.
    // There is no backpressure: the requester must take the response in that cycle.
    assign accept = (state_q == IDLE) && (mem_cs == SEL_CODE);

    always_comb begin
        state_d = state_q;
        ready_d = 1'b0;
        den_d   = 1'b0;
        dout_d  = 64'd0;
        we      = 1'b0;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    state_d = RESP;
                    ready_d = 1'b1;
                    if (mem_write_en) begin
                        we = ~bad_align & reset_n;
                    end else if (!bad_align) begin
                        den_d  = 1'b1;
                        dout_d = rd_lane;
                    end
                end
            end
            RESP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
            ready_q <= 1'b0;
            den_q   <= 1'b0;
            dout_q  <= 64'd0;
        end else begin
            state_q <= state_d;
            ready_q <= ready_d;
            den_q   <= den_d;
            dout_q  <= dout_d;
        end
    end

    // Storage is deliberately outside the reset domain so contents survive reset.
    always_ff @(posedge clock) begin
        if (we) begin
            mem_q[idx] <= wr_word;
        end
    end

`ifdef MEM_ALIGN_CHECK_EN
    logic err_q;

    assign bad_align = |(off_raw & ~align_mask);

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            err_q <= 1'b0;
        end else begin
            err_q <= accept & bad_align;
        end
    end

    assign mem_err = err_q;
`else
    assign bad_align = 1'b0;
    assign mem_err   = 1'b0;
`endif

    assign ready       = ready_q;
    assign data_out_en = den_q;
    assign data_out    = dout_q;
    assign state_o     = (state_q == RESP);

endmodule

// File: tb/tb_data_mem_responder.sv
// Self-checking bench for data_mem_responder; reference model is a flat byte array.
// Expectations follow MEM_ALIGN_CHECK_EN when the bench is built with it defined.
module tb_data_mem_responder;

    localparam int         ADDR_BITS = 8;
    localparam logic [1:0] SEL       = 2'b01;
    localparam int         NBYTES    = 8 << ADDR_BITS;

    logic        clock        = 1'b0;
    logic        reset_n      = 1'b0;
    logic [1:0]  mem_cs       = 2'b00;
    logic        mem_write_en = 1'b0;
    logic [1:0]  size         = 2'b00;
    logic [63:0] address      = 64'd0;
    logic [63:0] data_in      = 64'd0;
    logic [63:0] data_out;
    logic        data_out_en;
    logic        ready;
    logic        mem_err;
    logic        state_o;

    int total = 0;
    int bad   = 0;

    logic [7:0]  ref_mem [NBYTES];
    logic [66:0] exp_q[$];
    logic [66:0] obs_resp;
    logic [66:0] obs_after;

    data_mem_responder #(.ADDR_BITS(ADDR_BITS), .SEL_CODE(SEL)) dut (
        .clock       (clock),
        .reset_n     (reset_n),
        .mem_cs      (mem_cs),
        .mem_write_en(mem_write_en),
        .size        (size),
        .address     (address),
        .data_in     (data_in),
        .data_out    (data_out),
        .data_out_en (data_out_en),
        .ready       (ready),
        .mem_err     (mem_err),
        .state_o     (state_o)
    );

    always #5 clock = ~clock;

    // ---------------- reference model ----------------
    function automatic logic model_misaligned(input logic [1:0] sz, input logic [63:0] a);
`ifdef MEM_ALIGN_CHECK_EN
        return (a % (64'd1 << sz)) != 64'd0;
`else
        return 1'b0;
`endif
    endfunction

    function automatic int model_base(input logic [1:0] sz, input logic [63:0] a);
        int n = 1 << sz;
        int b = int'(a % 64'(NBYTES));
        return b - (b % n);
    endfunction

    task automatic model_store(input logic [1:0] sz, input logic [63:0] a, input logic [63:0] d);
        int b = model_base(sz, a);
        if (model_misaligned(sz, a)) return;
        for (int i = 0; i < (1 << sz); i++) ref_mem[b + i] = d[8*i +: 8];
    endtask

    function automatic logic [63:0] model_load(input logic [1:0] sz, input logic [63:0] a);
        logic [63:0] r = 64'd0;
        int b = model_base(sz, a);
        for (int i = 0; i < (1 << sz); i++) r[8*i +: 8] = ref_mem[b + i];
        return r;
    endfunction

    // Expected {ready, data_out_en, mem_err, data_out} in the response cycle.
    function automatic logic [66:0] model_resp(input logic we, input logic [1:0] sz, input logic [63:0] a);
        if (model_misaligned(sz, a)) return {3'b101, 64'd0};
        if (we) return {3'b100, 64'd0};
        return {3'b110, model_load(sz, a)};
    endfunction

    // ---------------- driver ----------------
    task automatic issue(input logic we, input logic [1:0] sz, input logic [63:0] a, input logic [63:0] d);
        @(negedge clock);
        mem_cs = SEL; mem_write_en = we; size = sz; address = a; data_in = d;
        @(negedge clock);
        obs_resp = {ready, data_out_en, mem_err, data_out};
        mem_cs = 2'b00; mem_write_en = 1'b0;
        @(negedge clock);
        obs_after = {ready, data_out_en, mem_err, data_out};
    endtask

    // ---------------- tests ----------------
    task automatic test_reset;
        reset_n = 1'b0;
        repeat (2) @(posedge clock);
        @(negedge clock);
        total++;
        if ({ready, data_out_en, mem_err, state_o, data_out} !== 68'd0) begin
            bad++;
            $display("FAIL reset_outputs: got rdy=%b en=%b err=%b st=%b dout=%h, expected all zero",
                     ready, data_out_en, mem_err, state_o, data_out);
        end
        reset_n = 1'b1;
    endtask

    task automatic test_dword_roundtrip;
        logic [66:0] e;
        issue(1'b1, 2'b11, 64'h40, 64'h0123_4567_89AB_CDEF);
        model_store(2'b11, 64'h40, 64'h0123_4567_89AB_CDEF);
        total++;
        if (obs_resp !== {3'b100, 64'd0}) begin
            bad++; $display("FAIL dw_store_resp: got %h expected %h", obs_resp, {3'b100, 64'd0});
        end
        issue(1'b0, 2'b11, 64'h40, 64'd0);
        e = {3'b110, 64'h0123_4567_89AB_CDEF};
        total++;
        if (obs_resp !== e) begin
            bad++; $display("FAIL dw_load_resp: got %h expected %h", obs_resp, e);
        end
        total++;
        if (obs_after !== 67'd0) begin
            bad++; $display("FAIL dw_load_after: got %h expected 0", obs_after);
        end
    endtask

    task automatic test_byte_merge;
        logic [66:0] e;
        issue(1'b1, 2'b00, 64'h43, 64'hFFFF_FFFF_FFFF_FFAA);
        model_store(2'b00, 64'h43, 64'hFFFF_FFFF_FFFF_FFAA);
        total++;
        if (obs_resp !== {3'b100, 64'd0}) begin
            bad++; $display("FAIL byte_store_resp: got %h expected %h", obs_resp, {3'b100, 64'd0});
        end
        issue(1'b0, 2'b11, 64'h40, 64'd0);
        e = {3'b110, 64'h0123_4567_AAAB_CDEF};
        total++;
        if (obs_resp !== e) begin
            bad++; $display("FAIL merge_dw_load: got %h expected %h", obs_resp, e);
        end
        issue(1'b0, 2'b00, 64'h43, 64'd0);
        e = {3'b110, 64'h0000_0000_0000_00AA};
        total++;
        if (obs_resp !== e) begin
            bad++; $display("FAIL merge_byte_load: got %h expected %h", obs_resp, e);
        end
    endtask

    task automatic test_wrap;
        logic [66:0] e;
        issue(1'b1, 2'b00, 64'h800, 64'h55);
        model_store(2'b00, 64'h800, 64'h55);
        issue(1'b0, 2'b00, 64'h000, 64'd0);
        e = {3'b110, 64'h55};
        total++;
        if (obs_resp !== e) begin
            bad++; $display("FAIL wrap_load: got %h expected %h", obs_resp, e);
        end
    endtask

    task automatic test_misaligned_half;
        logic [66:0] es, el;
`ifdef MEM_ALIGN_CHECK_EN
        es = {3'b101, 64'd0};
        el = {3'b110, 64'h0000_0000_AAAB_CDEF};
`else
        es = {3'b100, 64'd0};
        el = {3'b110, 64'h0000_0000_AAAB_BEEF};
`endif
        issue(1'b1, 2'b01, 64'h41, 64'hBEEF);
        model_store(2'b01, 64'h41, 64'hBEEF);
        total++;
        if (obs_resp !== es) begin
            bad++; $display("FAIL misaligned_store_resp: got %h expected %h", obs_resp, es);
        end
        issue(1'b0, 2'b10, 64'h40, 64'd0);
        total++;
        if (obs_resp !== el) begin
            bad++; $display("FAIL misaligned_word_load: got %h expected %h", obs_resp, el);
        end
    endtask

    task automatic test_held_select(input int hold);
        logic [3:0]  rdy_seq = 4'd0;
        logic [3:0]  exp_seq;
        logic [63:0] dout_c4 = 64'd0;
        logic [63:0] e = model_load(2'b11, 64'h40);
        // Cycle 1 carries the select; the response is in cycle 2, and a select
        // still present in cycle 3 (first IDLE cycle) yields a second response in cycle 4.
        exp_seq = (hold >= 3) ? 4'b0101 : 4'b0001;
        @(negedge clock);
        mem_cs = SEL; mem_write_en = 1'b0; size = 2'b11; address = 64'h40;
        for (int c = 2; c <= 5; c++) begin
            @(negedge clock);
            rdy_seq[c-2] = ready;
            if (c == 4) dout_c4 = data_out;
            if (c == hold + 1) mem_cs = 2'b00;
        end
        total++;
        if (rdy_seq !== exp_seq) begin
            bad++; $display("FAIL held_select_%0d: got ready cycles2..5=%b expected %b", hold, rdy_seq, exp_seq);
        end
        if (hold >= 3) begin
            total++;
            if (dout_c4 !== e) begin
                bad++; $display("FAIL held_select_second_data: got %h expected %h", dout_c4, e);
            end
        end
    endtask

    task automatic test_reset_during_resp;
        @(negedge clock);
        mem_cs = SEL; mem_write_en = 1'b0; size = 2'b11; address = 64'h40;
        @(negedge clock);
        total++;
        if (ready !== 1'b1) begin
            bad++; $display("FAIL rst_resp_precheck: got ready=%b expected 1", ready);
        end
        reset_n = 1'b0;
        mem_cs  = 2'b00;
        #1;
        total++;
        if ({ready, data_out_en, data_out} !== 66'd0) begin
            bad++; $display("FAIL rst_in_resp: got rdy=%b en=%b dout=%h expected all zero",
                            ready, data_out_en, data_out);
        end
        @(negedge clock);
        reset_n = 1'b1;
        @(negedge clock);
        total++;
        if ({state_o, ready} !== 2'b00) begin
            bad++; $display("FAIL rst_release_idle: got st=%b rdy=%b expected 0 0", state_o, ready);
        end
    endtask

    task automatic test_persist;
        logic [66:0] e = model_resp(1'b0, 2'b11, 64'h40);
        issue(1'b0, 2'b11, 64'h40, 64'd0);
        total++;
        if (obs_resp !== e) begin
            bad++; $display("FAIL persist_after_reset: got %h expected %h", obs_resp, e);
        end
    endtask

    task automatic test_random;
        logic        we;
        logic [1:0]  sz;
        logic [63:0] a, d, hi;
        logic [66:0] e;
        for (int w = 0; w < 32; w++) begin
            d = {$urandom, $urandom};
            issue(1'b1, 2'b11, 64'(w * 8), d);
            model_store(2'b11, 64'(w * 8), d);
        end
        for (int n = 0; n < 80; n++) begin
            we = 1'($urandom_range(0, 1));
            sz = 2'($urandom_range(0, 3));
            hi = {$urandom, $urandom};
            a  = {hi[63:11], 3'b000, 5'($urandom_range(0, 31)), 3'($urandom_range(0, 7))};
            d  = {$urandom, $urandom};
            exp_q.push_back(model_resp(we, sz, a));
            issue(we, sz, a, d);
            if (we) model_store(sz, a, d);
            e = exp_q.pop_front();
            total++;
            if (obs_resp !== e) begin
                bad++; $display("FAIL random_%0d we=%b sz=%0d addr=%h: got %h expected %h", n, we, sz, a, obs_resp, e);
            end
        end
    endtask

    initial begin
        test_reset();
        test_dword_roundtrip();
        test_byte_merge();
        test_wrap();
        test_misaligned_half();
        test_held_select(2);
        test_held_select(3);
        test_reset_during_resp();
        test_persist();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
